// File: rtl/noc_echo_responder_pkg.sv
// Shared definitions for the request/response NoC endpoints: header field layout,
// a packed header view for the default mesh size, and the responder FSM states.
package noc_echo_responder_pkg;

   localparam int NOC_DEF_XW = 2;
   localparam int NOC_DEF_YW = 2;
   localparam int NOC_DEF_LW = 5;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      DROP,
      TX_HDR,
      TX_PL
   } responder_state_t;

   // Header fields are packed LSB first: dst_x, dst_y, src_x, src_y, len.
   typedef struct packed {
      logic [NOC_DEF_LW-1:0] len;
      logic [NOC_DEF_YW-1:0] srcY;
      logic [NOC_DEF_XW-1:0] srcX;
      logic [NOC_DEF_YW-1:0] dstY;
      logic [NOC_DEF_XW-1:0] dstX;
   } noc_header_t;

   function automatic int hdrDstYOff(input int xw);
      return xw;
   endfunction

   function automatic int hdrSrcXOff(input int xw, input int yw);
      return xw + yw;
   endfunction

   function automatic int hdrSrcYOff(input int xw, input int yw);
      return 2 * xw + yw;
   endfunction

   function automatic int hdrLenOff(input int xw, input int yw);
      return 2 * xw + 2 * yw;
   endfunction

   function automatic int hdrWidth(input int xw, input int yw, input int lw);
      return 2 * xw + 2 * yw + lw;
   endfunction

endpackage

// File: rtl/noc_echo_responder_if.sv
// One direction of a valid/ready packet stream (tdata/tvalid/tlast with tready back).
interface noc_echo_responder_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/noc_echo_responder_payload_buffer.sv
// Simple dual-port payload store: one synchronous write port, one combinational read port.
module noc_payload_buffer #(
   parameter int DATA_WIDTH    = 32,
   parameter int BUFFER_LENGTH = 16,
   parameter int AW            = $clog2(BUFFER_LENGTH)
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_idx_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]         rd_idx_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [BUFFER_LENGTH];

   // Contents need no reset: the responder only reads entries written for the current packet.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/noc_echo_responder.sv
// Responder endpoint: checks request headers, buffers payload and echoes it back inverted
// to the source router as a response packet.
module noc_echo_responder
   import noc_echo_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_ROUTERS_X = 4,
   parameter int MAX_ROUTERS_Y = 4,
   parameter int ROUTER_X      = 0,
   parameter int ROUTER_Y      = 0,
   parameter int BUFFER_LENGTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   noc_echo_responder_if.slave  req,
   noc_echo_responder_if.master resp,
   output logic [15:0]          misroute_cnt_o,
   output logic                 overflow_o
);

   localparam int XW = $clog2(MAX_ROUTERS_X);
   localparam int YW = $clog2(MAX_ROUTERS_Y);
   localparam int LW = $clog2(BUFFER_LENGTH + 1);
   localparam int AW = $clog2(BUFFER_LENGTH);

   localparam int DST_Y_OFF = hdrDstYOff(XW);
   localparam int SRC_X_OFF = hdrSrcXOff(XW, YW);
   localparam int SRC_Y_OFF = hdrSrcYOff(XW, YW);
   localparam int HDR_W     = hdrWidth(XW, YW, LW);

   localparam logic [XW-1:0] MY_X     = XW'(ROUTER_X);
   localparam logic [YW-1:0] MY_Y     = YW'(ROUTER_Y);
   localparam logic [LW-1:0] BUF_FULL = LW'(BUFFER_LENGTH);

   responder_state_t      state_q, state_d;
   logic [LW-1:0]         cnt_q, cnt_d;
   logic [LW-1:0]         rdIdx_q, rdIdx_d;
   logic [XW-1:0]         srcX_q, srcX_d;
   logic [YW-1:0]         srcY_q, srcY_d;
   logic [15:0]           misroute_q, misroute_d;
   logic                  overflow_q, overflow_d;
   logic                  live_q;

   logic                  reqReady;
   logic                  reqFire;
   logic                  reqDstMatch;
   logic                  bufWrEn;
   logic                  respValid;
   logic                  respLast;
   logic [DATA_WIDTH-1:0] respData;
   logic [DATA_WIDTH-1:0] bufRdData;
   logic [HDR_W-1:0]      respHdr;

   assign reqDstMatch = (req.tdata[0 +: XW] == MY_X) && (req.tdata[DST_Y_OFF +: YW] == MY_Y);
   assign respHdr     = {cnt_q, MY_Y, MY_X, srcY_q, srcX_q};

   noc_payload_buffer #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUFFER_LENGTH(BUFFER_LENGTH),
      .AW           (AW)
   ) u_buffer (
      .clk_i    (clk_i),
      .wr_en_i  (bufWrEn),
      .wr_idx_i (cnt_q[AW-1:0]),
      .wr_data_i(req.tdata),
      .rd_idx_i (rdIdx_q[AW-1:0]),
      .rd_data_o(bufRdData)
   );

   // live_q keeps tready low while reset is held and for the first cycle after it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rdIdx_q    <= '0;
         srcX_q     <= '0;
         srcY_q     <= '0;
         misroute_q <= '0;
         overflow_q <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdIdx_q    <= rdIdx_d;
         srcX_q     <= srcX_d;
         srcY_q     <= srcY_d;
         misroute_q <= misroute_d;
         overflow_q <= overflow_d;
         live_q     <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdIdx_d    = rdIdx_q;
      srcX_d     = srcX_q;
      srcY_d     = srcY_q;
      misroute_d = misroute_q;
      overflow_d = overflow_q;
      bufWrEn    = 1'b0;
      respValid  = 1'b0;
      respLast   = 1'b0;
      respData   = '0;
      reqReady   = live_q && (state_q == IDLE || state_q == RX || state_q == DROP);
      reqFire    = reqReady && req.tvalid;

      case (state_q)
         IDLE: begin
            if (reqFire) begin
               cnt_d = '0;
               if (reqDstMatch) begin
                  srcX_d  = req.tdata[SRC_X_OFF +: XW];
                  srcY_d  = req.tdata[SRC_Y_OFF +: YW];
                  state_d = req.tlast ? TX_HDR : RX;
               end else begin
                  if (misroute_q != 16'hFFFF) begin
                     misroute_d = misroute_q + 16'd1;
                  end
                  state_d = req.tlast ? IDLE : DROP;
               end
            end
         end
         RX: begin
            if (reqFire) begin
               // Beats beyond the buffer are swallowed so the packet still terminates cleanly.
               if (cnt_q == BUF_FULL) begin
                  overflow_d = 1'b1;
               end else begin
                  bufWrEn = 1'b1;
                  cnt_d   = cnt_q + LW'(1);
               end
               if (req.tlast) begin
                  state_d = TX_HDR;
               end
            end
         end
         DROP: begin
            if (reqFire && req.tlast) begin
               state_d = IDLE;
            end
         end
         TX_HDR: begin
            respValid = 1'b1;
            respData  = DATA_WIDTH'(respHdr);
            respLast  = (cnt_q == '0);
            if (resp.tready) begin
               rdIdx_d = '0;
               state_d = (cnt_q == '0) ? IDLE : TX_PL;
            end
         end
         TX_PL: begin
            respValid = 1'b1;
            respData  = ~bufRdData;
            respLast  = (rdIdx_q == cnt_q - LW'(1));
            if (resp.tready) begin
               if (respLast) begin
                  state_d = IDLE;
               end else begin
                  rdIdx_d = rdIdx_q + LW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req.tready     = reqReady;
   assign resp.tvalid    = respValid;
   assign resp.tdata     = respData;
   assign resp.tlast     = respLast;
   assign misroute_cnt_o = misroute_q;
   assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_noc_echo_responder.sv
// Directed plus randomized bench for noc_echo_responder, checked against a packet-level
// reference model of the echo behaviour.
module tb_noc_echo_responder;

   localparam int DW   = 32;
   localparam int BL   = 16;
   localparam int MY_X = 0;
   localparam int MY_Y = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] misrouteCnt;
   logic        overflow;

   noc_echo_responder_if #(.DATA_WIDTH(DW)) reqIf ();
   noc_echo_responder_if #(.DATA_WIDTH(DW)) respIf ();

   noc_echo_responder #(
      .DATA_WIDTH   (DW),
      .MAX_ROUTERS_X(4),
      .MAX_ROUTERS_Y(4),
      .ROUTER_X     (MY_X),
      .ROUTER_Y     (MY_Y),
      .BUFFER_LENGTH(BL)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req           (reqIf),
      .resp          (respIf),
      .misroute_cnt_o(misrouteCnt),
      .overflow_o    (overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] reqPayload[$];
   logic [31:0] expResp[$];
   int          expMisroute = 0;
   logic        expOverflow = 1'b0;

   // 4x4 mesh, 16-beat buffer: x/y fields are 2 bits each, len is 5 bits starting at bit 8.
   function automatic logic [31:0] mkHdr(input int dx, input int dy, input int sx, input int sy, input int len);
      return 32'(dx + dy * 4 + sx * 16 + sy * 64 + (len % 32) * 256);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".reqReady"}, 32'(reqIf.tready), 0);
      checkOutput({tag, ".respValid"}, 32'(respIf.tvalid), 0);
      checkOutput({tag, ".respLast"}, 32'(respIf.tlast), 0);
      checkOutput({tag, ".respData"}, respIf.tdata, 0);
      checkOutput({tag, ".misroute"}, 32'(misrouteCnt), 0);
      checkOutput({tag, ".overflow"}, 32'(overflow), 0);
   endtask

   task automatic fillRandom(input int n);
      reqPayload.delete();
      repeat (n) reqPayload.push_back($urandom);
   endtask

   task automatic modelPacket(input int dx, input int dy, input int sx, input int sy);
      int kept;
      expResp.delete();
      if (dx == MY_X && dy == MY_Y) begin
         kept = (reqPayload.size() > BL) ? BL : reqPayload.size();
         if (reqPayload.size() > BL) expOverflow = 1'b1;
         expResp.push_back(mkHdr(sx, sy, MY_X, MY_Y, kept));
         for (int i = 0; i < kept; i++) expResp.push_back(~reqPayload[i]);
      end else if (expMisroute < 65535) begin
         expMisroute++;
      end
   endtask

   task automatic applyStimulus(input int dx, input int dy, input int sx, input int sy);
      logic [31:0] beats[$];
      logic        timedOut;
      int          waitCyc;
      timedOut = 1'b0;
      beats.push_back(mkHdr(dx, dy, sx, sy, reqPayload.size()));
      foreach (reqPayload[i]) beats.push_back(reqPayload[i]);
      for (int i = 0; i < beats.size(); i++) begin
         reqIf.tdata  = beats[i];
         reqIf.tvalid = 1'b1;
         reqIf.tlast  = (i == beats.size() - 1);
         waitCyc = 0;
         while (!reqIf.tready && waitCyc < 100) begin
            @(posedge clk); #1;
            waitCyc++;
         end
         if (waitCyc >= 100) timedOut = 1'b1;
         @(posedge clk); #1;
      end
      reqIf.tvalid = 1'b0;
      reqIf.tlast  = 1'b0;
      reqIf.tdata  = '0;
      checkOutput("reqTimeout", 32'(timedOut), 0);
   endtask

   task automatic collectResponse(input int stallAt, input int maxBeats);
      int          idx;
      int          waitCyc;
      logic        done;
      logic [31:0] held;
      idx = 0;
      waitCyc = 0;
      done = 1'b0;
      respIf.tready = 1'b1;
      while (!done && waitCyc < 300) begin
         if (respIf.tvalid) begin
            if (idx == stallAt) begin
               held = respIf.tdata;
               respIf.tready = 1'b0;
               for (int c = 0; c < 10; c++) begin
                  @(posedge clk); #1;
                  checkOutput("stallData", respIf.tdata, held);
                  checkOutput("stallValid", 32'(respIf.tvalid), 1);
                  checkOutput("stallReqReady", 32'(reqIf.tready), 0);
               end
               respIf.tready = 1'b1;
            end
            if (idx < expResp.size()) begin
               checkOutput("respBeat", respIf.tdata, expResp[idx]);
               checkOutput("respLast", 32'(respIf.tlast), 32'(idx == expResp.size() - 1));
            end else begin
               checkOutput("respExtraBeat", idx, expResp.size());
            end
            idx++;
            if (respIf.tlast || idx >= maxBeats) done = 1'b1;
         end
         @(posedge clk); #1;
         waitCyc++;
      end
      checkOutput("respTimeout", 32'(done), 1);
      if (maxBeats == expResp.size()) checkOutput("respCount", idx, expResp.size());
   endtask

   task automatic runPacket(input int dx, input int dy, input int sx, input int sy, input int stallAt);
      logic sawValid;
      modelPacket(dx, dy, sx, sy);
      applyStimulus(dx, dy, sx, sy);
      if (expResp.size() > 0) begin
         checkOutput("respRise", 32'(respIf.tvalid), 1);
         collectResponse(stallAt, expResp.size());
      end else begin
         sawValid = 1'b0;
         repeat (5) begin
            sawValid = sawValid | respIf.tvalid;
            @(posedge clk); #1;
         end
         checkOutput("noResp", 32'(sawValid), 0);
      end
      checkOutput("misroute", 32'(misrouteCnt), expMisroute);
      checkOutput("overflow", 32'(overflow), 32'(expOverflow));
   endtask

   initial begin
      int n;
      int dx;
      int dy;
      rst = 1'b1;
      reqIf.tdata = '0;
      reqIf.tvalid = 1'b0;
      reqIf.tlast = 1'b0;
      respIf.tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] echo of 3-beat payload from (2,3)");
      reqPayload = {32'd1, 32'd2, 32'd3};
      runPacket(0, 0, 2, 3, -1);

      $display("[TB] header-only request from (1,1)");
      reqPayload.delete();
      runPacket(0, 0, 1, 1, -1);

      $display("[TB] misrouted request to (3,1), then a valid one");
      fillRandom(3);
      runPacket(3, 1, 2, 2, -1);
      fillRandom(2);
      runPacket(0, 0, 3, 0, -1);

      $display("[TB] 20-beat payload truncated to buffer length");
      fillRandom(20);
      runPacket(0, 0, 1, 2, -1);
      fillRandom(1);
      runPacket(0, 0, 2, 1, -1);

      $display("[TB] response backpressure mid-payload");
      fillRandom(8);
      runPacket(0, 0, 3, 3, 4);

      $display("[TB] randomized packets");
      for (int k = 0; k < 12; k++) begin
         n = $urandom_range(0, 20);
         dx = MY_X;
         dy = MY_Y;
         if ($urandom_range(0, 3) == 0) begin
            dx = $urandom_range(1, 3);
            dy = $urandom_range(0, 3);
         end
         fillRandom(n);
         runPacket(dx, dy, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, n) : -1);
      end

      $display("[TB] reset during payload transmission");
      fillRandom(6);
      modelPacket(0, 0, 2, 2);
      applyStimulus(0, 0, 2, 2);
      collectResponse(-1, 3);
      respIf.tready = 1'b0;
      rst = 1'b1;
      #1;
      checkReset("midReset");
      @(posedge clk); #1;
      checkReset("heldReset");
      rst = 1'b0;
      expMisroute = 0;
      expOverflow = 1'b0;
      @(posedge clk); #1;
      fillRandom(5);
      runPacket(0, 0, 1, 3, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
